gfx256_wbm_read_arb: RTL and testbench

- Wishbone read master that services z-buffer and texture read requests from the clip and fragment stages.
- It is the responder end of the z_request/z_addr/z_sel/z_ack/z_data/wbm_busy handshake that the clip stage initiates.
- Arbitrates two requesters round-robin and issues single 256-bit Wishbone classic reads.
- Keeps a one-line buffer per requester, so repeated reads to the same 32-byte line complete without a bus cycle.

---
 rtl/gfx256_wbm_read_arb.sv | 145 ++++++++++++++
 tb/tb_gfx256_wbm_read_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gfx256_wbm_read_arb.sv
// Round-robin Wishbone read master for the z and texture requesters,
// with a one-line read buffer per port so same-line re-reads skip the bus.
module gfx256_wbm_read_arb #(
  parameter int MDW      = 256,
  parameter bit LINE_BUF = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           z_request_i,
  input  logic [31:0]    z_addr_i,
  input  logic [31:0]    z_sel_i,
  output logic           z_ack_o,
  output logic [MDW-1:0] z_data_o,
  input  logic           tex_request_i,
  input  logic [31:0]    tex_addr_i,
  input  logic [31:0]    tex_sel_i,
  output logic           tex_ack_o,
  output logic [MDW-1:0] tex_data_o,
  input  logic           z_inv_i,
  input  logic           tex_inv_i,
  output logic           busy_o,
  output logic           err_o,
  output logic           m_cyc_o,
  output logic           m_stb_o,
  output logic           m_we_o,
  output logic [31:0]    m_sel_o,
  output logic [31:0]    m_adr_o,
  input  logic [MDW-1:0] m_dat_i,
  input  logic           m_ack_i,
  input  logic           m_err_i
);

  localparam int OFS = $clog2(MDW / 8);
  localparam int TW  = 32 - OFS;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t         state, state_next;
  logic           gnt_tex, last_tex, pick_tex, any_req, hit;
  logic           inv_gnt, inv_seen, cyc;
  logic [31:0]    req_addr, req_sel, adr_q, sel_q;
  logic [TW-1:0]  z_tag, tex_tag;
  logic           z_valid, tex_valid;
  logic [MDW-1:0] z_line, tex_line;

  // With both requesting, last_tex picks the port not granted last.
  always_comb begin
    any_req  = z_request_i | tex_request_i;
    pick_tex = tex_request_i & (~z_request_i | ~last_tex);
    req_addr = pick_tex ? tex_addr_i : z_addr_i;
    req_sel  = pick_tex ? tex_sel_i : z_sel_i;
    if (pick_tex)
      hit = LINE_BUF && tex_valid && (tex_tag == req_addr[31:OFS]) && !tex_inv_i;
    else
      hit = LINE_BUF && z_valid && (z_tag == req_addr[31:OFS]) && !z_inv_i;
    inv_gnt = gnt_tex ? tex_inv_i : z_inv_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = hit ? RESP : BUS;
      BUS:     if (m_ack_i || m_err_i) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_tex   <= 1'b0;
      last_tex  <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      inv_seen  <= 1'b0;
      cyc       <= 1'b0;
      err_o     <= 1'b0;
      z_tag     <= '0;
      tex_tag   <= '0;
      z_valid   <= 1'b0;
      tex_valid <= 1'b0;
      z_line    <= '0;
      tex_line  <= '0;
    end else begin
      err_o <= 1'b0;
      if (z_inv_i)   z_valid   <= 1'b0;
      if (tex_inv_i) tex_valid <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          gnt_tex  <= pick_tex;
          last_tex <= pick_tex;
          adr_q    <= {req_addr[31:OFS], {OFS{1'b0}}};
          sel_q    <= req_sel;
          inv_seen <= 1'b0;
          cyc      <= !hit;
        end
        BUS: begin
          inv_seen <= inv_seen | inv_gnt;
          // Error outranks a simultaneous ack; a fill that overlaps an
          // invalidate is delivered but not kept valid.
          if (m_err_i) begin
            cyc   <= 1'b0;
            err_o <= 1'b1;
            if (gnt_tex) begin
              tex_line  <= '0;
              tex_valid <= 1'b0;
            end else begin
              z_line  <= '0;
              z_valid <= 1'b0;
            end
          end else if (m_ack_i) begin
            cyc <= 1'b0;
            if (gnt_tex) begin
              tex_line  <= m_dat_i;
              tex_tag   <= adr_q[31:OFS];
              tex_valid <= LINE_BUF && !(inv_seen || inv_gnt);
            end else begin
              z_line  <= m_dat_i;
              z_tag   <= adr_q[31:OFS];
              z_valid <= LINE_BUF && !(inv_seen || inv_gnt);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_cyc_o    = cyc;
  assign m_stb_o    = cyc;
  assign m_we_o     = 1'b0;
  assign m_adr_o    = adr_q;
  assign m_sel_o    = sel_q;
  assign busy_o     = (state != IDLE);
  assign z_ack_o    = (state == RESP) && !gnt_tex;
  assign tex_ack_o  = (state == RESP) && gnt_tex;
  assign z_data_o   = z_line;
  assign tex_data_o = tex_line;

endmodule

// File: tb/tb_gfx256_wbm_read_arb.sv
// Randomized bench for gfx256_wbm_read_arb against a transaction-level
// model of the two line buffers, the round-robin pointer and a memory.
module tb_gfx256_wbm_read_arb;

  logic         clk, rst;
  logic         z_request_i, tex_request_i, z_inv_i, tex_inv_i;
  logic [31:0]  z_addr_i, z_sel_i, tex_addr_i, tex_sel_i;
  logic         z_ack_o, tex_ack_o, busy_o, err_o;
  logic [255:0] z_data_o, tex_data_o, m_dat_i;
  logic         m_cyc_o, m_stb_o, m_we_o, m_ack_i, m_err_i;
  logic [31:0]  m_sel_o, m_adr_o;

  gfx256_wbm_read_arb #(.MDW(256), .LINE_BUF(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .z_request_i(z_request_i), .z_addr_i(z_addr_i), .z_sel_i(z_sel_i),
    .z_ack_o(z_ack_o), .z_data_o(z_data_o),
    .tex_request_i(tex_request_i), .tex_addr_i(tex_addr_i), .tex_sel_i(tex_sel_i),
    .tex_ack_o(tex_ack_o), .tex_data_o(tex_data_o),
    .z_inv_i(z_inv_i), .tex_inv_i(tex_inv_i),
    .busy_o(busy_o), .err_o(err_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i)
  );

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  // Reference model: per-port line buffer and last-granted pointer.
  bit           m_valid [2];
  logic [26:0]  m_tag   [2];
  logic [255:0] m_data  [2];
  bit           m_last_tex;

  // Memory responder controls and observations.
  int unsigned  resp_lat = 1;
  bit           resp_err = 0;
  bit           resp_both = 0;
  int           bus_starts = 0;
  int           resp_cyc = 0;
  int           cnt = 0;
  logic [31:0]  seen_adr, seen_sel;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_no <= cyc_no + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = ({5'b0, a[31:5]} * 32'h9E3779B1) ^ (32'h01010101 * i) ^ 32'h5A5A0000;
    return r;
  endfunction

  initial begin
    logic [255:0] junk;
    junk = {8{32'hDEADBEEF}};
    m_ack_i = 0; m_err_i = 0; m_dat_i = '0;
    forever begin
      @(negedge clk);
      if (m_cyc_o && !m_ack_i && !m_err_i) begin
        if (cnt == 0) begin
          bus_starts++;
          seen_adr = m_adr_o;
          seen_sel = m_sel_o;
        end
        cnt++;
        if (cnt >= resp_lat) begin
          m_err_i  = resp_err;
          m_ack_i  = resp_err ? resp_both : 1'b1;
          m_dat_i  = resp_err ? junk : mem_line(m_adr_o);
          resp_cyc = cyc_no;
        end
      end else begin
        m_ack_i = 0;
        m_err_i = 0;
        cnt = 0;
      end
    end
  end

  task automatic pulse_inv(input int p);
    @(posedge clk); #1;
    if (p == 0) z_inv_i = 1; else tex_inv_i = 1;
    @(posedge clk); #1;
    z_inv_i = 0; tex_inv_i = 0;
    m_valid[p] = 0;
  endtask

  task automatic service(input bit zr, input bit tr, input logic [31:0] za, input logic [31:0] ta,
                         input bit err_inj, input bit inv_mid, input int unsigned lat);
    bit           pend [2];
    logic [31:0]  pa [2];
    logic [31:0]  ps [2];
    int           p, gnt_cyc, starts0;
    bit           hit, got, inv_done;
    logic [255:0] exp_d;
    pa[0] = za; pa[1] = ta;
    ps[0] = $urandom; ps[1] = $urandom;
    pend[0] = zr; pend[1] = tr;
    @(posedge clk); #1;
    resp_lat = lat; resp_err = err_inj; resp_both = 1'($urandom_range(0, 1));
    z_request_i = zr; z_addr_i = za; z_sel_i = ps[0];
    tex_request_i = tr; tex_addr_i = ta; tex_sel_i = ps[1];
    gnt_cyc = cyc_no;
    while (pend[0] || pend[1]) begin
      p = (pend[0] && pend[1]) ? (m_last_tex ? 0 : 1) : (pend[1] ? 1 : 0);
      m_last_tex = (p == 1);
      hit = m_valid[p] && (m_tag[p] == pa[p][31:5]);
      starts0 = bus_starts; got = 0; inv_done = 0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (inv_mid && p == 0 && m_cyc_o && !inv_done) begin
          z_inv_i = 1; inv_done = 1;
        end else z_inv_i = 0;
        got = z_ack_o | tex_ack_o;
      end
      z_inv_i = 0;
      exp_d = hit ? m_data[p] : (err_inj ? 256'h0 : mem_line(pa[p]));
      if (!got) chk("ack_timeout", 0, 1);
      else begin
        chk("ack_port", {z_ack_o, tex_ack_o}, (p == 0) ? 2'b10 : 2'b01);
        chk("ack_data", (p == 0) ? z_data_o : tex_data_o, exp_d);
        chk("err_pulse", err_o, !hit && err_inj);
        chk("busy", busy_o, 1);
        chk("bus_reads", bus_starts - starts0, hit ? 0 : 1);
        if (hit) chk("hit_latency", cyc_no - gnt_cyc, 1);
        else begin
          chk("miss_latency", cyc_no - resp_cyc, 1);
          chk("bus_adr", seen_adr, {pa[p][31:5], 5'b0});
          chk("bus_sel", seen_sel, ps[p]);
        end
      end
      if (!hit) begin
        m_tag[p]   = pa[p][31:5];
        m_data[p]  = exp_d;
        m_valid[p] = !err_inj && !inv_done;
      end
      @(posedge clk); #1;
      if (p == 0) z_request_i = 0; else tex_request_i = 0;
      pend[p] = 0;
      gnt_cyc = cyc_no;
    end
    resp_err = 0;
  endtask

  task automatic reset_mid_bus();
    bit acks;
    @(posedge clk); #1;
    resp_lat = 20; resp_err = 0;
    z_request_i = 1; z_addr_i = 32'h0000_3000; z_sel_i = '1;
    for (int k = 0; k < 10 && !m_cyc_o; k++) @(negedge clk);
    chk("rst_cyc_start", m_cyc_o, 1);
    #2 rst = 1;
    #1;
    chk("rst_cyc_async", {m_cyc_o, m_stb_o, busy_o}, 3'b000);
    z_request_i = 0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks = acks | z_ack_o | tex_ack_o;
    end
    chk("rst_no_ack", acks, 0);
    @(posedge clk); #1;
    rst = 0;
    m_valid[0] = 0; m_valid[1] = 0; m_last_tex = 0;
  endtask

  initial begin
    bit zr, tr, er, iv;
    logic [31:0] za, ta;
    rst = 1;
    z_request_i = 0; tex_request_i = 0; z_inv_i = 0; tex_inv_i = 0;
    z_addr_i = '0; z_sel_i = '0; tex_addr_i = '0; tex_sel_i = '0;
    m_valid[0] = 0; m_valid[1] = 0; m_last_tex = 0;
    m_data[0] = '0; m_data[1] = '0; m_tag[0] = '0; m_tag[1] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {m_cyc_o, m_stb_o, m_we_o, z_ack_o, tex_ack_o, busy_o, err_o}, 7'b0);
    chk("rst_adr", m_adr_o, 0);
    chk("rst_sel", m_sel_o, 0);
    chk("rst_zdata", z_data_o, 0);
    chk("rst_texdata", tex_data_o, 0);
    @(posedge clk); #1;
    rst = 0;

    service(1, 0, 32'h0000_1040, 0, 0, 0, 3);
    service(1, 0, 32'h0000_105C, 0, 0, 0, 1);
    pulse_inv(0);
    service(1, 0, 32'h0000_105C, 0, 0, 0, 2);
    for (int i = 0; i < 4; i++)
      service(1, 1, 32'h0000_4000 + 32'(i * 64), 32'h0000_8000 + 32'(i * 64), 0, 0, 1 + i);
    service(0, 1, 0, 32'h0000_9000, 1, 0, 2);
    service(0, 1, 0, 32'h0000_9000, 0, 0, 1);
    service(1, 0, 32'h0000_2000, 0, 0, 1, 3);
    service(1, 0, 32'h0000_2004, 0, 0, 0, 1);
    reset_mid_bus();
    service(1, 0, 32'h0000_1040, 0, 0, 0, 2);

    for (int i = 0; i < 40; i++) begin
      zr = 1'($urandom_range(0, 1));
      tr = zr ? 1'($urandom_range(0, 1)) : 1'b1;
      za = 32'h0000_1000 + ($urandom_range(0, 3) << 5) + $urandom_range(0, 31);
      ta = 32'h0000_8000 + ($urandom_range(0, 3) << 5) + $urandom_range(0, 31);
      er = ($urandom_range(0, 7) == 0);
      iv = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) pulse_inv(int'($urandom_range(0, 1)));
      service(zr, tr, za, ta, er, iv, $urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
